vram_arbiter: RTL and testbench

Shares one single-port synchronous cell RAM (snake playfield, GRID_W x GRID_H cells) between three users. The first is display scan-out, driven by the 800x600 timing generator's pixel coordinates and given fixed, never-stalled slots. The second is the game engine's read/write port, using a req/ack handshake. The third is an internal bulk-clear engine. The block sits between the VGA timing generator, the game FSM and the cell RAM.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vram_arbiter_cell_tracker.sv | 75 +++++++
 rtl/vram_arbiter.sv | 149 ++++++++++++++
 tb/tb_vram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared playfield/VGA constants for the snake display path and its cell RAM.
// Cell codes, grid geometry and the scan-out pipeline latency live here.
package vga_pkg;

  localparam int H_ACTIVE    = 800;
  localparam int V_ACTIVE    = 600;
  localparam int CELL_SIZE   = 20;
  localparam int GRID_W      = H_ACTIVE / CELL_SIZE;
  localparam int GRID_H      = V_ACTIVE / CELL_SIZE;
  localparam int N_CELLS     = GRID_W * GRID_H;
  localparam int ADDR_W      = 11;
  localparam int DATA_W      = 4;
  localparam int PIX_LATENCY = 3;

  localparam logic [DATA_W-1:0] CELL_EMPTY = 4'd0;
  localparam logic [DATA_W-1:0] CELL_SNAKE = 4'd1;
  localparam logic [DATA_W-1:0] CELL_FOOD  = 4'd2;
  localparam logic [DATA_W-1:0] CELL_WALL  = 4'd3;

  typedef enum logic {
    CLR_IDLE,
    CLR_CLEAR
  } clr_state_t;

  typedef enum logic [1:0] {
    SLOT_NONE,
    SLOT_DISP,
    SLOT_GAME,
    SLOT_CLEAR
  } slot_t;

endpackage

// File: rtl/vram_arbiter_cell_tracker.sv
// Follows the scan position in cell units and flags the first pixel of each
// visible cell, together with its linear RAM address (no multiplier).
module cell_tracker #(
  parameter int CELL_SIZE = 20,
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_valid,
  output logic              slot,
  output logic [ADDR_W-1:0] addr
);

  localparam int SW = $clog2(CELL_SIZE);
  localparam int CW = $clog2(GRID_W + 1);
  localparam int RW = $clog2(GRID_H + 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(CELL_SIZE - 1);

  logic [SW-1:0]     xsub_q, xsub_c, ysub_q, ysub_c;
  logic [CW-1:0]     col_q, col_c;
  logic [RW-1:0]     row_q, row_c;
  logic [ADDR_W-1:0] base_q, base_c;
  logic              line_start;

  assign line_start = pix_valid && (pix_x == '0);

  // Position of the pixel presented this cycle; registers hold the next one.
  always_comb begin
    xsub_c = xsub_q;
    col_c  = col_q;
    ysub_c = ysub_q;
    row_c  = row_q;
    base_c = base_q;
    if (line_start) begin
      xsub_c = '0;
      col_c  = '0;
      if (pix_y == '0) begin
        ysub_c = '0;
        row_c  = '0;
        base_c = '0;
      end else if (ysub_q == SUB_LAST) begin
        ysub_c = '0;
        row_c  = row_q + 1'b1;
        base_c = base_q + ADDR_W'(GRID_W);
      end else begin
        ysub_c = ysub_q + 1'b1;
      end
    end
  end

  assign slot = pix_valid && (xsub_c == '0) && (col_c < CW'(GRID_W)) &&
                (row_c < RW'(GRID_H));
  assign addr = base_c + ADDR_W'(col_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xsub_q <= '0;
      col_q  <= '0;
      ysub_q <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else if (pix_valid) begin
      xsub_q <= (xsub_c == SUB_LAST) ? '0 : xsub_c + 1'b1;
      col_q  <= (xsub_c == SUB_LAST) ? col_c + 1'b1 : col_c;
      ysub_q <= ysub_c;
      row_q  <= row_c;
      base_q <= base_c;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port cell RAM arbiter: fixed display read slots, a bulk clear engine
// and a game req/ack port share the remaining cycles in that priority order.
module vram_arbiter #(
  parameter int CELL_SIZE = vga_pkg::CELL_SIZE,
  parameter int GRID_W    = vga_pkg::GRID_W,
  parameter int GRID_H    = vga_pkg::GRID_H,
  parameter int DATA_W    = vga_pkg::DATA_W,
  parameter int ADDR_W    = vga_pkg::ADDR_W,
  parameter logic [DATA_W-1:0] CLR_VAL = DATA_W'(vga_pkg::CELL_EMPTY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_valid,
  output logic [DATA_W-1:0] disp_cell,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              gm_req,
  input  logic              gm_we,
  input  logic [ADDR_W-1:0] gm_addr,
  input  logic [DATA_W-1:0] gm_wdata,
  output logic              gm_ack,
  output logic              gm_rvalid,
  output logic [DATA_W-1:0] gm_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
);

  import vga_pkg::*;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(GRID_W * GRID_H - 1);

  clr_state_t        state, state_d;
  slot_t             grant;
  logic [ADDR_W-1:0] clr_addr, clr_addr_d;
  logic              last_grant, last_q;
  logic              disp_slot;
  logic [ADDR_W-1:0] disp_addr;
  logic [1:0]        disp_rd, gm_rd;

  cell_tracker #(
    .CELL_SIZE(CELL_SIZE),
    .GRID_W   (GRID_W),
    .GRID_H   (GRID_H),
    .ADDR_W   (ADDR_W)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_valid(pix_valid),
    .slot     (disp_slot),
    .addr     (disp_addr)
  );

  assign clr_busy = (state == CLR_CLEAR);

  // The game also waits through a clear's final write and through the cycle a
  // clear is being started, so a pending request is served after clr_done.
  always_comb begin
    state_d    = state;
    clr_addr_d = clr_addr;
    grant      = SLOT_NONE;
    last_grant = 1'b0;
    if (disp_slot) begin
      grant = SLOT_DISP;
    end else if (state == CLR_CLEAR) begin
      grant = SLOT_CLEAR;
    end else if (gm_req && !gm_ack && !last_q && !clr_start) begin
      grant = SLOT_GAME;
    end
    case (state)
      CLR_IDLE: begin
        if (clr_start) begin
          state_d    = CLR_CLEAR;
          clr_addr_d = '0;
        end
      end
      CLR_CLEAR: begin
        if (grant == SLOT_CLEAR) begin
          clr_addr_d = clr_addr + 1'b1;
          if (clr_addr == CLR_LAST) begin
            state_d    = CLR_IDLE;
            last_grant = 1'b1;
          end
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLR_IDLE;
      clr_addr <= '0;
      last_q   <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_d;
      clr_addr <= clr_addr_d;
      last_q   <= last_grant;
      clr_done <= last_q;
    end
  end

  // RAM command in G+1, read data in G+2, captured result visible from G+3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      gm_ack    <= 1'b0;
      gm_rvalid <= 1'b0;
      gm_rdata  <= '0;
      disp_cell <= '0;
      disp_rd   <= '0;
      gm_rd     <= '0;
    end else begin
      gm_ack  <= (grant == SLOT_GAME);
      disp_rd <= {disp_rd[0], grant == SLOT_DISP};
      gm_rd   <= {gm_rd[0], (grant == SLOT_GAME) && !gm_we};
      case (grant)
        SLOT_DISP: begin
          ram_addr <= disp_addr;
          ram_we   <= 1'b0;
        end
        SLOT_GAME: begin
          ram_addr  <= gm_addr;
          ram_we    <= gm_we;
          ram_wdata <= gm_wdata;
        end
        SLOT_CLEAR: begin
          ram_addr  <= clr_addr;
          ram_we    <= 1'b1;
          ram_wdata <= CLR_VAL;
        end
        default: ram_we <= 1'b0;
      endcase
      if (disp_rd[1]) disp_cell <= ram_rdata;
      gm_rvalid <= gm_rd[1];
      if (gm_rd[1]) gm_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, cell-level display/clear/game model with a
// per-cycle compare, and directed scenarios with hand-computed expectations.
module tb_vram_arbiter;
  import vga_pkg::*;

  localparam int N   = GRID_W * GRID_H;
  localparam int TMO = 5000;

  logic              clk, rst;
  logic [9:0]        pix_x, pix_y;
  logic              pix_valid;
  logic [DATA_W-1:0] disp_cell;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              gm_req, gm_we;
  logic [ADDR_W-1:0] gm_addr;
  logic [DATA_W-1:0] gm_wdata;
  logic              gm_ack, gm_rvalid;
  logic [DATA_W-1:0] gm_rdata;
  logic              clr_start, clr_busy, clr_done;

  vram_arbiter dut (
    .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .disp_cell(disp_cell), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .gm_req(gm_req),
    .gm_we(gm_we), .gm_addr(gm_addr), .gm_wdata(gm_wdata), .gm_ack(gm_ack),
    .gm_rvalid(gm_rvalid), .gm_rdata(gm_rdata), .clr_start(clr_start),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- RAM model (1-cycle synchronous read) ----------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = DATA_W'(k % 16);
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- model + scoreboard ----------------
  logic [DATA_W-1:0] golden [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_disp, p1_val;
  logic              p0_v, p1_v, m_busy, last_wr, exp_done;
  int                p0_a, m_cnt, cyc, clr_wr_total, done_cnt, done_cyc;
  int                ack_cnt, rv_cnt;

  initial begin
    for (int k = 0; k < (1 << ADDR_W); k++) golden[k] = DATA_W'(k % 16);
    {p0_v, p1_v, m_busy, last_wr, exp_done} = '0;
    exp_disp = '0; p1_val = '0; p0_a = 0; m_cnt = 0; cyc = 0;
    clr_wr_total = 0; done_cnt = 0; done_cyc = 0; ack_cnt = 0; rv_cnt = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        p0_v = 0; p1_v = 0; exp_disp = '0; m_busy = 0; m_cnt = 0; last_wr = 0;
        exp_q.delete();
      end else begin
        // Display: first pixel of a visible cell -> RAM sampled one edge later,
        // disp_cell shows it after the following edge.
        if (p1_v) exp_disp = p1_val;
        p1_v   = p0_v;
        p1_val = golden[p0_a];
        p0_v = pix_valid && pix_x < 10'(H_ACTIVE) && pix_y < 10'(V_ACTIVE) &&
               (int'(pix_x) % CELL_SIZE == 0);
        p0_a = p0_v ? (int'(pix_y) / CELL_SIZE) * GRID_W + int'(pix_x) / CELL_SIZE : 0;
        if (clr_start && !m_busy) begin
          m_busy = 1; m_cnt = 0;
        end
      end
      @(negedge clk);
      if (rst) begin
        exp_done = last_wr;
        last_wr  = 0;
        if (p0_v) begin
          chk("slot_addr", int'(ram_addr), p0_a);
          chk("slot_we", int'(ram_we), 0);
        end
        if (ram_we) begin
          if (m_busy) begin
            chk("clr_addr", int'(ram_addr), m_cnt);
            chk("clr_data", int'(ram_wdata), 0);
            golden[m_cnt] = '0;
            m_cnt++;
            clr_wr_total++;
            if (m_cnt == N) begin m_busy = 0; last_wr = 1; end
          end else if (gm_ack && gm_we) begin
            chk("gm_wr_addr", int'(ram_addr), int'(gm_addr));
            chk("gm_wr_data", int'(ram_wdata), int'(gm_wdata));
            golden[gm_addr] = gm_wdata;
          end else begin
            chk("stray_write", 1, 0);
          end
        end
        if (gm_ack) begin
          ack_cnt++;
          chk("ack_while_clear", int'(m_busy), 0);
          if (!gm_we) begin
            chk("gm_rd_addr", int'(ram_addr), int'(gm_addr));
            chk("gm_rd_we", int'(ram_we), 0);
            exp_q.push_back(golden[gm_addr]);
          end
        end
        if (gm_rvalid) begin
          rv_cnt++;
          if (exp_q.size() == 0) chk("rvalid_unexpected", 1, 0);
          else chk("gm_rdata", int'(gm_rdata), int'(exp_q.pop_front()));
        end
        chk("disp_cell", int'(disp_cell), int'(exp_disp));
        chk("clr_busy", int'(clr_busy), int'(m_busy));
        chk("clr_done", int'(clr_done), int'(exp_done));
        if (clr_done) begin done_cnt++; done_cyc = cyc; end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pin(input int y, input int x);
    if (y == 0 && x == 22)  chk("pin_row0_x22", int'(disp_cell), 0);
    if (y == 0 && x == 23)  chk("pin_row0_x23", int'(disp_cell), 1);
    if (y == 0 && x == 63)  chk("pin_row0_x63", int'(disp_cell), 3);
    if (y == 0 && x == 223) chk("pin_row0_x223", int'(disp_cell), 11);
    if (y == 20 && x == 1)  chk("pin_line20_addr", int'(ram_addr), 40);
    if (y == 20 && x == 2)  chk("pin_line20_x2", int'(disp_cell), 0);
    if (y == 20 && x == 3)  chk("pin_line20_x3", int'(disp_cell), 8);
    if (y == 20 && x == 23) chk("pin_line20_x23", int'(disp_cell), 9);
  endtask

  task automatic drive_line(input int y, input int n);
    for (int x = 0; x < n; x++) begin
      @(posedge clk); #1;
      pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
      @(negedge clk);
      pin(y, x);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic blank(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic gm_access(input logic we, input int a, input int d,
                           output int ack_lat, output int rv_lat,
                           output int ack_at, output int rd);
    @(posedge clk); #1;
    gm_req = 1'b1; gm_we = we; gm_addr = ADDR_W'(a); gm_wdata = DATA_W'(d);
    ack_lat = 0; rv_lat = 0; rd = 0;
    do begin @(negedge clk); ack_lat++; end while (!gm_ack && ack_lat < TMO);
    if (!gm_ack) chk("gm_ack_timeout", 0, 1);
    ack_at = cyc;
    @(posedge clk); #1;
    gm_req = 1'b0;
    if (!we) begin
      do begin @(negedge clk); rv_lat++; end while (!gm_rvalid && rv_lat < TMO);
      if (!gm_rvalid) chk("gm_rvalid_timeout", 0, 1);
      rd = int'(gm_rdata);
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_start = 1'b1;
    @(posedge clk); #1 clr_start = 1'b0;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_disp_cell"}, int'(disp_cell), 0);
    chk({tag, "_ram_addr"}, int'(ram_addr), 0);
    chk({tag, "_ram_we"}, int'(ram_we), 0);
    chk({tag, "_ram_wdata"}, int'(ram_wdata), 0);
    chk({tag, "_gm_ack"}, int'(gm_ack), 0);
    chk({tag, "_gm_rvalid"}, int'(gm_rvalid), 0);
    chk({tag, "_gm_rdata"}, int'(gm_rdata), 0);
    chk({tag, "_clr_busy"}, int'(clr_busy), 0);
    chk({tag, "_clr_done"}, int'(clr_done), 0);
  endtask

  // ---------------- directed scenarios ----------------
  int lat, rvl, ack_at, rd, a0, r0, w0, d0, t;

  initial begin
    rst = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
    gm_req = 1'b0; gm_we = 1'b0; gm_addr = '0; gm_wdata = '0; clr_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_outs_zero("reset");
    @(posedge clk); #1 rst = 1'b1;
    blank(2);

    // Row 0 full scan, then 19 short lines, then line 20 (row 1 starts at 40).
    drive_line(0, 800);
    blank(20);
    for (int y = 1; y < 20; y++) begin
      drive_line(y, 4);
      blank(4);
    end
    drive_line(20, 60);
    blank(6);

    // Game write issued on a display-slot cycle waits exactly one extra cycle.
    fork
      drive_line(21, 60);
      gm_access(1'b1, 5, 9, lat, rvl, ack_at, rd);
    join
    chk("wr_on_slot_ack_lat", lat, 3);
    blank(6);
    gm_access(1'b0, 5, 0, lat, rvl, ack_at, rd);
    chk("rd_free_ack_lat", lat, 2);
    chk("rd_rvalid_lat", rvl, 2);
    chk("rd_addr5_data", rd, 9);
    blank(4);

    // Back-to-back reads with gm_req held high.
    a0 = ack_cnt; r0 = rv_cnt;
    @(posedge clk); #1;
    gm_req = 1'b1; gm_we = 1'b0; gm_addr = ADDR_W'(1);
    for (int i = 1; i <= 3; i++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!gm_ack && t < TMO);
      chk("burst_ack_seen", int'(gm_ack), 1);
      @(posedge clk); #1;
      if (i < 3) gm_addr = ADDR_W'(i + 1);
      else gm_req = 1'b0;
    end
    blank(8);
    chk("burst_ack_count", ack_cnt - a0, 3);
    chk("burst_rvalid_count", rv_cnt - r0, 3);

    // Clear during active video, re-pulsed mid-clear, with a blocked game read.
    w0 = clr_wr_total; d0 = done_cnt;
    fork
      for (int y = 22; y < 30; y++) begin
        drive_line(y, 800);
        blank(40);
      end
      begin
        blank(10);
        pulse_clr();
        blank(5);
        @(negedge clk) chk("clr_busy_pin", int'(clr_busy), 1);
        blank(100);
        pulse_clr();
      end
      begin
        blank(20);
        gm_access(1'b0, 7, 0, lat, rvl, ack_at, rd);
        chk("ack_after_done", int'(ack_at > done_cyc && done_cnt - d0 == 1), 1);
        chk("rd_after_clear", rd, 0);
      end
    join
    chk("clr_write_count", clr_wr_total - w0, N);
    chk("clr_done_count", done_cnt - d0, 1);

    // Reset in the middle of a clear, then restart from address 0.
    blank(4);
    pulse_clr();
    t = 0;
    do begin @(negedge clk); t++; end while (m_cnt < 600 && t < TMO);
    chk("clr_reached_600", int'(m_cnt >= 600), 1);
    #2 rst = 1'b0;
    #1 chk_outs_zero("midclr_reset");
    @(posedge clk); #1 rst = 1'b1;
    blank(3);
    w0 = clr_wr_total; d0 = done_cnt;
    pulse_clr();
    t = 0;
    do begin @(negedge clk); t++; end while (!ram_we && t < TMO);
    chk("restart_addr", int'(ram_addr), 0);
    t = 0;
    while (done_cnt == d0 && t < TMO) begin @(negedge clk); t++; end
    chk("restart_done", done_cnt - d0, 1);
    chk("restart_write_count", clr_wr_total - w0, N);
    blank(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
